video_path_mux: RTL and testbench
=================================

# video_path_mux

Frame-synchronous, parametrised selector for the HDMI pixel path. It takes NUM_CH processed video streams (e.g. bypass RGB, gray-scaled Y, FIR output), each with its own pipeline latency, and applies per-channel delay compensation so that all streams line up. It then forwards exactly one stream to the HDMI transmitter. Selection changes requested by the MicroBlaze are deferred to the next frame start, so the output never switches mid-frame. It sits in the `rx_clk` domain between the processing modules and `hdmi_tx`.

## Interface
- NUM_CH, 3, number of input streams (2..8)
- DW, 8, bits per colour component
- MAX_DLY, 15, maximum per-channel compensation delay in cycles
- DLY_W, 4, width of one delay field; must hold MAX_DLY
- SEL_W, 3, width of the select value; must hold NUM_CH
- RESET_SEL, 0, selection after reset

- clk  in  1  pixel clock (`rx_clk`); all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch_r_i / ch_g_i / ch_b_i  in  NUM_CH*DW each  colour per channel; channel k is at bits [k*DW +: DW]
- ch_dv_i / ch_hs_i / ch_vs_i  in  NUM_CH each  timing per channel; all active-high
- dly_i  in  NUM_CH*DLY_W  compensation delay per channel; quasi-static
- sel_i  in  SEL_W  requested channel; values >= NUM_CH select BLANK
- sel_req_i  in  1  one-cycle strobe; samples sel_i
- r_o / g_o / b_o  out  DW each  selected colour
- dv_o / hs_o / vs_o  out  1 each  selected timing
- active_sel_o  out  SEL_W  selection currently applied
- pending_o  out  1  a request is waiting for the next frame start
- switch_done_o  out  1  one-cycle pulse when a pending request commits

## Operation
- **Delay lines.** Each channel k has a shift register of depth MAX_DLY, width 3*DW+3. The aligned stream A_k is the tap dly_k, where dly_k = 0 means the undelayed input.
  - dly_k > MAX_DLY clamps to MAX_DLY.
  - A change to dly_i takes effect on the next cycle. Software changes it only while BLANK is selected, so glitches are tolerated.
- **Frame-start edge.** fs = A_0.vs == 1 and A_0.vs registered one cycle earlier == 0. Channel 0 is the timing reference for every selection.
- **FSM states:** IDLE, PENDING.
  - IDLE + sel_req_i: capture sel_i into pend_sel, go to PENDING. This holds even if fs is high in the same cycle; that edge is not used.
  - PENDING + fs: commit active_sel <= pend_sel, go to IDLE, pulse switch_done_o.
  - PENDING + sel_req_i without fs: overwrite pend_sel (latest wins), stay in PENDING.
  - PENDING + fs + sel_req_i: commit the old pend_sel, pulse switch_done_o, capture the new sel_i, stay in PENDING.
- **Effective select.** eff = pend_sel when (PENDING && fs), otherwise active_sel. The frame's first vs cycle therefore already carries the new channel.
- **Output mux.**
  - eff < NUM_CH: output register takes A_eff (colour and timing).
  - eff >= NUM_CH (BLANK): r/g/b = 0, dv/hs/vs taken from A_0.
- **Status outputs.** active_sel_o is the registered active_sel, which may be a BLANK code. pending_o is the registered (state == PENDING).

## Timing
- Latency from channel k input to output is dly_k + 1 cycles; the output is registered.
- switch_done_o is asserted in the same cycle that the first output word of the new selection appears.
- active_sel_o updates together with switch_done_o.
- pending_o goes high 1 cycle after the accepting sel_req_i. It goes low together with switch_done_o, unless a request was captured in that same cycle.
- Reset, asynchronous on rst_n low:
  - All outputs are 0, except active_sel_o = RESET_SEL.
  - pending_o = 0, state = IDLE.
  - Delay lines and the fs history register are cleared.
  - Release is synchronous to clk. A request pending when reset asserts is discarded.
- If a request arrives while no vs edge ever occurs (e.g. no HDMI input), it stays pending indefinitely. No timeout.
- Throughput is one pixel per cycle with no stalls.

## Test plan
- **Reset.** Hold rst_n low with random inputs.
  - Required: all outputs 0, active_sel_o = 0.
  - Release rst_n with dly = {0,0,0}. Required: output = ch0 delayed by exactly 1 cycle.
- **Delay alignment.** dly = {3,7,0}, drive the same frame into every channel with skews of 0, -4 and +3 cycles.
  - Required: for sel = 0, 1 and 2, the output vs rising edge lands in the identical cycle, with 4 cycles of latency relative to ch0.
- **Deferred switch.** Mid-frame, pulse sel_req_i with sel_i = 2.
  - Required: pending_o = 1, and output stays on ch0 until the ch0-aligned vs rise.
  - On that rise: ch2 data appears, switch_done_o = 1 for one cycle, active_sel_o = 2, pending_o = 0.
- **Latest wins.** Request sel = 1, then sel = 2, in the same frame.
  - Required: a single switch_done_o at the next vs rise, with active_sel_o = 2.
- **Collision.** Request sel = 1 in the cycle fs occurs while pend_sel = 2 is pending.
  - Required: that frame switches to 2 with switch_done_o = 1 and pending_o staying 1.
  - The following frame switches to 1.
- **BLANK and clamp.** Request sel = 7 with NUM_CH = 3.
  - Required: from the next frame start, r/g/b = 0 and timing follows ch0.
  - Set dly_0 = 15 with MAX_DLY = 15, then write an out-of-range value (use DLY_W = 5 with value 20). Required: latency clamps to 16 cycles.

Source files
------------

// File: rtl/video_path_mux.sv
// Frame-synchronous stream selector for the HDMI pixel path: per-channel latency
// compensation, then a registered mux whose selection only changes at a frame start.
module video_path_mux #(
    parameter int NUM_CH    = 3,
    parameter int DW        = 8,
    parameter int MAX_DLY   = 15,
    parameter int DLY_W     = 4,
    parameter int SEL_W     = 3,
    parameter int RESET_SEL = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*DW-1:0]    ch_r_i,
    input  logic [NUM_CH*DW-1:0]    ch_g_i,
    input  logic [NUM_CH*DW-1:0]    ch_b_i,
    input  logic [NUM_CH-1:0]       ch_dv_i,
    input  logic [NUM_CH-1:0]       ch_hs_i,
    input  logic [NUM_CH-1:0]       ch_vs_i,
    input  logic [NUM_CH*DLY_W-1:0] dly_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    sel_req_i,
    output logic [DW-1:0]           r_o,
    output logic [DW-1:0]           g_o,
    output logic [DW-1:0]           b_o,
    output logic                    dv_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic [SEL_W-1:0]        active_sel_o,
    output logic                    pending_o,
    output logic                    switch_done_o
);

    // Word layout: {r, g, b, dv, hs, vs}
    localparam int PW = 3*DW + 3;
    localparam logic [DLY_W-1:0] MAX_TAP = DLY_W'(MAX_DLY);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [PW-1:0]    in_word_s [NUM_CH];
    logic [PW-1:0]    dline_r   [NUM_CH][MAX_DLY];
    logic [PW-1:0]    aligned_s [NUM_CH];
    logic             vs_hist_r;
    logic             fs_s;
    state_t           state_r;
    state_t           next_state_s;
    logic [SEL_W-1:0] pend_sel_r;
    logic [SEL_W-1:0] active_sel_r;
    logic [SEL_W-1:0] eff_sel_s;
    logic             capture_s;
    logic             commit_s;
    logic [PW-1:0]    mux_word_s;
    logic [PW-1:0]    out_word_r;
    logic             pending_r;
    logic             switch_done_r;

    // Pack each channel's colour and timing into one word
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            in_word_s[k] = {ch_r_i[k*DW +: DW], ch_g_i[k*DW +: DW], ch_b_i[k*DW +: DW],
                            ch_dv_i[k], ch_hs_i[k], ch_vs_i[k]};
        end
    end

    // Per-channel compensation shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                for (int i = 0; i < MAX_DLY; i++) begin
                    dline_r[k][i] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                dline_r[k][0] <= in_word_s[k];
                for (int i = 1; i < MAX_DLY; i++) begin
                    dline_r[k][i] <= dline_r[k][i-1];
                end
            end
        end
    end

    // Tap selection; oversized delay requests saturate at the deepest tap
    always_comb begin
        logic [DLY_W-1:0] tap_v;
        logic [PW-1:0]    word_v;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dly_i[k*DLY_W +: DLY_W] > MAX_TAP) begin
                tap_v = MAX_TAP;
            end else begin
                tap_v = dly_i[k*DLY_W +: DLY_W];
            end
            word_v = in_word_s[k];
            for (int i = 1; i <= MAX_DLY; i++) begin
                if (tap_v == DLY_W'(i)) begin
                    word_v = dline_r[k][i-1];
                end else begin
                    word_v = word_v;
                end
            end
            aligned_s[k] = word_v;
        end
    end

    // Channel 0 is the frame timing reference
    assign fs_s = aligned_s[0][0] & ~vs_hist_r;

    // Frame-start history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_hist_r <= 1'b0;
        end else begin
            vs_hist_r <= aligned_s[0][0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: a request arriving with fs keeps the FSM pending
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_req_i) begin
                    next_state_s = ST_PENDING;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (fs_s && !sel_req_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PENDING;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: capture/commit strobes and the select used this cycle
    always_comb begin
        capture_s = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                capture_s = sel_req_i;
                commit_s  = 1'b0;
            end
            ST_PENDING: begin
                capture_s = sel_req_i;
                commit_s  = fs_s;
            end
            default: begin
                capture_s = 1'b0;
                commit_s  = 1'b0;
            end
        endcase
        eff_sel_s = commit_s ? pend_sel_r : active_sel_r;
    end

    // Selection and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_sel_r    <= {SEL_W{1'b0}};
            active_sel_r  <= SEL_W'(RESET_SEL);
            pending_r     <= 1'b0;
            switch_done_r <= 1'b0;
        end else begin
            if (capture_s) begin
                pend_sel_r <= sel_i;
            end
            if (commit_s) begin
                active_sel_r <= pend_sel_r;
            end
            pending_r     <= (next_state_s == ST_PENDING);
            switch_done_r <= commit_s;
        end
    end

    // Output mux; out-of-range selects blank colour but keep channel 0 timing
    always_comb begin
        logic [PW-1:0] sel_word_v;
        sel_word_v = {{(3*DW){1'b0}}, aligned_s[0][2:0]};
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff_sel_s == SEL_W'(k)) begin
                sel_word_v = aligned_s[k];
            end else begin
                sel_word_v = sel_word_v;
            end
        end
        mux_word_s = sel_word_v;
    end

    // Output pixel register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_r <= '0;
        end else begin
            out_word_r <= mux_word_s;
        end
    end

    assign r_o           = out_word_r[3+2*DW +: DW];
    assign g_o           = out_word_r[3+DW +: DW];
    assign b_o           = out_word_r[3 +: DW];
    assign dv_o          = out_word_r[2];
    assign hs_o          = out_word_r[1];
    assign vs_o          = out_word_r[0];
    assign active_sel_o  = active_sel_r;
    assign pending_o     = pending_r;
    assign switch_done_o = switch_done_r;

endmodule

// File: tb/tb_video_path_mux.sv
// Bench for video_path_mux: reset/latency vector table, then frame-based
// sequences for deferred switching, collisions, BLANK and delay clamping.
module tb_video_path_mux;

    localparam int NUM_CH = 3;
    localparam int DW     = 8;
    localparam int MAX_DLY = 15;
    localparam int DLY_W  = 5;
    localparam int SEL_W  = 3;
    localparam int FRAME  = 20;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH*DW-1:0]    ch_r_i, ch_g_i, ch_b_i;
    logic [NUM_CH-1:0]       ch_dv_i, ch_hs_i, ch_vs_i;
    logic [NUM_CH*DLY_W-1:0] dly_i;
    logic [SEL_W-1:0]        sel_i;
    logic                    sel_req_i;
    logic [DW-1:0]           r_o, g_o, b_o;
    logic                    dv_o, hs_o, vs_o;
    logic [SEL_W-1:0]        active_sel_o;
    logic                    pending_o;
    logic                    switch_done_o;

    video_path_mux #(
        .NUM_CH(NUM_CH), .DW(DW), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W),
        .SEL_W(SEL_W), .RESET_SEL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_r_i(ch_r_i), .ch_g_i(ch_g_i), .ch_b_i(ch_b_i),
        .ch_dv_i(ch_dv_i), .ch_hs_i(ch_hs_i), .ch_vs_i(ch_vs_i),
        .dly_i(dly_i), .sel_i(sel_i), .sel_req_i(sel_req_i),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .active_sel_o(active_sel_o), .pending_o(pending_o),
        .switch_done_o(switch_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, g, b;
        logic [2:0] t;      // {dv, hs, vs}
        logic [7:0] o;      // colour seed for channels 1 and 2
        logic [7:0] er, eg, eb;
        logic [2:0] et;
    } vec_t;

    vec_t tab [6];
    int   skew [NUM_CH] = '{0, -4, 3};
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   cur      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cur, act, exp);
        end
    endtask

    function automatic int phase(input int m);
        return ((m % FRAME) + FRAME) % FRAME;
    endfunction

    function automatic logic [2:0] tim(input int m);
        int p;
        p = phase(m);
        return {(p >= 4 && p < 18), (p % 5 == 0), (p < 2)};
    endfunction

    // Expected output word for a given selection and source index
    function automatic logic [26:0] exp_word(input int sel, input int m);
        if (sel < NUM_CH)
            return {8'(m), 8'(m*7 + 1), 8'(16*(sel + 1)), tim(m)};
        else
            return {24'h0, tim(m)};
    endfunction

    task automatic drive_gen(input int n);
        int m;
        logic [2:0] t;
        for (int k = 0; k < NUM_CH; k++) begin
            m = n - skew[k];
            t = tim(m);
            ch_r_i[k*DW +: DW] = 8'(m);
            ch_g_i[k*DW +: DW] = 8'(m*7 + 1);
            ch_b_i[k*DW +: DW] = 8'(16*(k + 1));
            ch_dv_i[k] = t[2];
            ch_hs_i[k] = t[1];
            ch_vs_i[k] = t[0];
        end
    endtask

    task automatic drive_vec(input logic [7:0] r, g, b, input logic [2:0] t, input logic [7:0] o);
        ch_r_i[DW-1:0] = r;
        ch_g_i[DW-1:0] = g;
        ch_b_i[DW-1:0] = b;
        {ch_dv_i[0], ch_hs_i[0], ch_vs_i[0]} = t;
        for (int k = 1; k < NUM_CH; k++) begin
            ch_r_i[k*DW +: DW] = o;
            ch_g_i[k*DW +: DW] = ~o;
            ch_b_i[k*DW +: DW] = o ^ 8'h0F;
            {ch_dv_i[k], ch_hs_i[k], ch_vs_i[k]} = ~t;
        end
    endtask

    task automatic tick();
        drive_gen(cyc);
        @(posedge clk);
        #1;
        cur = cyc;
        cyc++;
    endtask

    task automatic tick_chk(input int sel, input int shift);
        tick();
        chk("data", {r_o, g_o, b_o, dv_o, hs_o, vs_o}, exp_word(sel, cur - shift));
    endtask

    task automatic status_chk(input string nm, input logic p, input logic d, input int a);
        chk(nm, {pending_o, switch_done_o, active_sel_o}, {p, d, 3'(a)});
    endtask

    function automatic bit fs_next();
        return phase(cyc - 3) == 0;
    endfunction

    task automatic adv_to(input int ph, input int sel);
        for (int i = 0; i < 2*FRAME; i++) begin
            if (phase(cyc - 3) == ph) break;
            tick_chk(sel, 3);
        end
    endtask

    task automatic wait_fs(input int sel, input int act);
        for (int i = 0; i < 2*FRAME; i++) begin
            if (fs_next()) break;
            tick_chk(sel, 3);
            status_chk("wait_pending", 1'b1, 1'b0, act);
        end
    endtask

    task automatic req(input int s);
        sel_i     = 3'(s);
        sel_req_i = 1'b1;
    endtask

    initial begin
        // Hand-computed vectors: each row expects the previous row's ch0 inputs
        tab[0] = '{8'hA5, 8'h5A, 8'h01, 3'b001, 8'hFF, 8'd11, 8'd22, 8'd33, 3'b000};
        tab[1] = '{8'h00, 8'hFF, 8'h80, 3'b110, 8'h77, 8'hA5, 8'h5A, 8'h01, 3'b001};
        tab[2] = '{8'h12, 8'h34, 8'h56, 3'b111, 8'h00, 8'h00, 8'hFF, 8'h80, 3'b110};
        tab[3] = '{8'hFE, 8'h01, 8'h7F, 3'b010, 8'hC3, 8'h12, 8'h34, 8'h56, 3'b111};
        tab[4] = '{8'h3C, 8'hC3, 8'h99, 3'b100, 8'h3C, 8'hFE, 8'h01, 8'h7F, 3'b010};
        tab[5] = '{8'h00, 8'h00, 8'h00, 3'b000, 8'hAA, 8'h3C, 8'hC3, 8'h99, 3'b100};

        rst_n = 1'b0;
        sel_i = '0;
        sel_req_i = 1'b0;
        dly_i = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            ch_r_i = 24'($urandom); ch_g_i = 24'($urandom); ch_b_i = 24'($urandom);
            ch_dv_i = 3'($urandom); ch_hs_i = 3'($urandom); ch_vs_i = 3'($urandom);
            dly_i = 15'($urandom); sel_i = 3'($urandom); sel_req_i = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset_state", {r_o, g_o, b_o, dv_o, hs_o, vs_o, active_sel_o, pending_o, switch_done_o}, 64'h0);
        end

        // Release with zero delay: output is ch0 one cycle later
        sel_req_i = 1'b0;
        dly_i = '0;
        drive_vec(8'd11, 8'd22, 8'd33, 3'b000, 8'h66);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("latency1", {r_o, g_o, b_o, dv_o, hs_o, vs_o},
                {tab[i].er, tab[i].eg, tab[i].eb, tab[i].et});
            drive_vec(tab[i].r, tab[i].g, tab[i].b, tab[i].t, tab[i].o);
        end

        // Skewed channels with compensation {ch2=0, ch1=7, ch0=3}
        dly_i = {5'd0, 5'd7, 5'd3};
        cyc = 0;
        for (int i = 0; i < 20; i++) tick();

        // Deferred switch 0 -> 2
        adv_to(8, 0);
        req(2);
        tick_chk(0, 3);
        sel_req_i = 1'b0;
        status_chk("req_accept", 1'b1, 1'b0, 0);
        wait_fs(0, 0);
        tick_chk(2, 3);
        status_chk("switch_to_2", 1'b0, 1'b1, 2);
        tick_chk(2, 3);
        status_chk("done_pulse_end", 1'b0, 1'b0, 2);

        // Back to channel 0
        req(0);
        tick_chk(2, 3);
        sel_req_i = 1'b0;
        wait_fs(2, 2);
        tick_chk(0, 3);
        status_chk("switch_to_0", 1'b0, 1'b1, 0);

        // Latest request in a frame wins
        adv_to(5, 0);
        req(1);
        tick_chk(0, 3);
        sel_req_i = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk(0, 3);
        req(2);
        tick_chk(0, 3);
        sel_req_i = 1'b0;
        status_chk("latest_pending", 1'b1, 1'b0, 0);
        wait_fs(0, 0);
        tick_chk(2, 3);
        status_chk("latest_switch", 1'b0, 1'b1, 2);
        tick_chk(2, 3);
        status_chk("latest_single", 1'b0, 1'b0, 2);

        // Collision: new request in the fs cycle while 2 is pending
        adv_to(10, 2);
        req(2);
        tick_chk(2, 3);
        sel_req_i = 1'b0;
        wait_fs(2, 2);
        req(1);
        tick_chk(2, 3);
        sel_req_i = 1'b0;
        status_chk("collision_commit", 1'b1, 1'b1, 2);
        wait_fs(2, 2);
        tick_chk(1, 3);
        status_chk("collision_next", 1'b0, 1'b1, 1);

        // BLANK select
        adv_to(10, 1);
        req(7);
        tick_chk(1, 3);
        sel_req_i = 1'b0;
        wait_fs(1, 1);
        tick_chk(7, 3);
        status_chk("blank_switch", 1'b0, 1'b1, 7);
        for (int i = 0; i < FRAME; i++) tick_chk(7, 3);

        // Deepest tap and saturation of an oversized delay
        dly_i[4:0] = 5'd15;
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < FRAME; i++) tick_chk(7, 15);
        dly_i[4:0] = 5'd20;
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < FRAME; i++) tick_chk(7, 15);
        status_chk("clamp_status", 1'b0, 1'b0, 7);

        // Asynchronous reset discards a pending request
        req(1);
        tick();
        sel_req_i = 1'b0;
        status_chk("pre_reset_pending", 1'b1, 1'b0, 7);
        rst_n = 1'b0;
        #2;
        chk("async_reset", {r_o, g_o, b_o, dv_o, hs_o, vs_o, active_sel_o, pending_o, switch_done_o}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
